alu_program_sequencer: RTL and testbench
========================================

Name: alu_program_sequencer

Overview:
Micro-sequencer that drives the shared combinational ALU and the 16-entry register file from a small, loadable instruction store. Each instruction takes a fixed FETCH/EXEC/WRITE sequence. The block runs one instruction per step pulse or continuously while run is high. It sits between the board-level key pulse generators and the ALU/regfile datapath, replacing manual operand/opcode loading for program demos such as Fibonacci.

Parameters:
ADDR_W, 4, instruction-store address width; depth = 2**ADDR_W
INSTR_W, 25, instruction width: [24] imm_sel, [23:16] opcode, [15:12] rdest, [11:8] rsrc, [7:0] imm
WAIT_OP, 8'h00, no-op opcode; never writes back
HALT_OP, 8'hFF, halt opcode; never reaches the ALU

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
step_pulse  in  1  one-cycle pulse; executes one instruction when IDLE
run  in  1  level; while high, instructions execute back-to-back
clear_pulse  in  1  one-cycle pulse; synchronous abort, pc := 0
prog_we  in  1  instruction-store write enable
prog_addr  in  ADDR_W  instruction-store write address
prog_data  in  INSTR_W  instruction-store write data
alu_flags  in  5  ALU combinational flags
opcode  out  8  ALU opcode
rdest_sel  out  4  register-file destination/read-A select
rsrc_sel  out  4  register-file read-B select
imm_sel  out  1  1: ALU B operand = imm
imm  out  16  imm field, sign-extended from 8 bits
wEnable  out  1  register-file write strobe, one cycle
pc  out  ADDR_W  address of the next instruction to fetch
flags_q  out  5  flags latched at the last write-back
busy  out  1  high in FETCH, EXEC or WRITE
halted  out  1  high in HALTED
instr_count  out  16  count of retired non-WAIT, non-HALT instructions

Behaviour:
- Reset (async, reset_n low):
  - State = IDLE; pc = 0; instruction register = 0.
  - Outputs: opcode = 8'h00, all selects 0, imm = 0, wEnable = 0, flags_q = 0, busy = 0, halted = 0, instr_count = 0.
  - Instruction store is not reset (contents undefined until written).
- Instruction store:
  - Register array with asynchronous read at pc.
  - Written on a clock edge when prog_we = 1, but only in IDLE or HALTED. Writes in other states are ignored.
- States: IDLE, FETCH, EXEC, WRITE, HALTED.
- IDLE:
  - Go to FETCH if step_pulse = 1 or run = 1.
  - All outputs are registered; opcode = WAIT_OP while IDLE.
- FETCH:
  - Latch mem[pc] into the instruction register.
  - If the fetched opcode == HALT_OP, go to HALTED; pc is not advanced.
  - Otherwise go to EXEC.
- EXEC:
  - Drive opcode, rdest_sel, rsrc_sel, imm_sel and imm from the instruction register.
  - wEnable = 0. ALU settles this cycle. Go to WRITE.
- WRITE:
  - Hold all EXEC outputs.
  - If opcode != WAIT_OP: wEnable = 1, flags_q <= alu_flags, instr_count += 1 (wraps at 16'hFFFF -> 0).
  - If opcode == WAIT_OP: wEnable = 0; flags_q and instr_count hold.
  - pc <= pc + 1, wrapping from 2**ADDR_W - 1 to 0.
  - Next state: FETCH if run = 1, otherwise IDLE.
- HALTED:
  - halted = 1, opcode = WAIT_OP.
  - step_pulse and run are ignored; only clear_pulse or reset exits.
- clear_pulse has priority over every other input in every state:
  - Next state = IDLE, pc = 0, wEnable forced 0 that cycle.
  - flags_q and instr_count hold.
- Latency: step_pulse sampled at edge N → FETCH N+1, EXEC N+2, WRITE N+3 (wEnable high) → IDLE N+4. Run mode retires one instruction per 3 cycles.
- step_pulse arriving while busy or HALTED is dropped, not queued.
- busy = (state ∈ {FETCH, EXEC, WRITE}).

Test Plan:
- Reset: hold reset_n = 0 mid-WRITE → wEnable, busy, halted, pc, instr_count all 0 immediately, without waiting for a clock edge.
- Single step: mem[0] = {1'b1, 8'h05, 4'd1, 4'd0, 8'hFE}, step_pulse → two cycles later opcode = 8'h05, rdest_sel = 1, imm = 16'hFFFE; then wEnable high exactly one cycle, pc = 1, instr_count = 1, flags_q = alu_flags.
- WAIT: mem[1] opcode 8'h00, step_pulse → wEnable stays 0, pc = 2, instr_count unchanged.
- Run and wrap: 16 ADD instructions, run held high → 16 wEnable strobes spaced 3 cycles apart; pc wraps 15 → 0; instr_count = 16 after 48 cycles.
- HALT: mem[2] = HALT_OP, run = 1 → halted = 1, pc stays 2, no wEnable; a following step_pulse is ignored; clear_pulse → IDLE, pc = 0.
- Collisions: prog_we asserted during EXEC → store unchanged; clear_pulse in the same cycle as WRITE → wEnable 0, pc = 0, state IDLE.

Source files
------------

// File: rtl/alu_program_sequencer.sv
// alu_program_sequencer
// Micro-sequencer that steps a small loadable instruction store through a
// fixed FETCH -> EXEC -> WRITE sequence. It drives the shared ALU opcode and
// operand selects and the register-file write strobe.
//
// Ports:
//   CLOCK_50     system clock
//   reset_n      asynchronous active-low reset
//   step_pulse   one-cycle pulse, executes one instruction from IDLE
//   run          level, executes instructions back-to-back while high
//   clear_pulse  synchronous abort: back to IDLE with pc = 0 (highest priority)
//   prog_we/prog_addr/prog_data  instruction-store write port (IDLE/HALTED only)
//   alu_flags    ALU flags, latched into flags_q at write-back
//   opcode, rdest_sel, rsrc_sel, imm_sel, imm   ALU/regfile controls
//   wEnable      register-file write strobe (one cycle, in WRITE)
//   pc           address of the next instruction to fetch
//   flags_q      flags captured at the last write-back
//   busy/halted  state indicators
//   instr_count  retired non-WAIT, non-HALT instructions (wrapping)
// Instruction word: [24] imm_sel, [23:16] opcode, [15:12] rdest, [11:8] rsrc, [7:0] imm
module alu_program_sequencer #(
    parameter int          ADDR_W  = 4,
    parameter int          INSTR_W = 25,
    parameter logic [7:0]  WAIT_OP = 8'h00,
    parameter logic [7:0]  HALT_OP = 8'hFF
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               step_pulse,
    input  logic               run,
    input  logic               clear_pulse,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [4:0]         alu_flags,
    output logic [7:0]         opcode,
    output logic [3:0]         rdest_sel,
    output logic [3:0]         rsrc_sel,
    output logic               imm_sel,
    output logic [15:0]        imm,
    output logic               wEnable,
    output logic [ADDR_W-1:0]  pc,
    output logic [4:0]         flags_q,
    output logic               busy,
    output logic               halted,
    output logic [15:0]        instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WRITE,
        S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    // The registered output fields double as the instruction register: they
    // are loaded at the FETCH->EXEC edge and held through WRITE.
    logic [7:0]          opcode_q, opcode_d;
    logic [3:0]          rdest_q, rdest_d;
    logic [3:0]          rsrc_q, rsrc_d;
    logic                imm_sel_q, imm_sel_d;
    logic [15:0]         imm_q, imm_d;
    logic                wen_q, wen_d;
    logic [4:0]          flags_d;
    logic [15:0]         count_q, count_d;

    logic [INSTR_W-1:0]  mem_q [2**ADDR_W];
    logic [INSTR_W-1:0]  fetch_word;

    assign fetch_word = mem_q[pc_q];

    // Store is only writable while the sequencer is not using it.
    always_ff @(posedge CLOCK_50) begin
        if (prog_we && (state_q == S_IDLE || state_q == S_HALTED)) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        rdest_d   = rdest_q;
        rsrc_d    = rsrc_q;
        imm_sel_d = imm_sel_q;
        imm_d     = imm_q;
        wen_d     = 1'b0;
        flags_d   = flags_q;
        count_d   = count_q;

        if (clear_pulse) begin
            state_d  = S_IDLE;
            pc_d     = '0;
            opcode_d = WAIT_OP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (step_pulse || run) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetch_word[23:16] == HALT_OP) begin
                        // HALT never reaches the ALU and does not advance pc.
                        state_d  = S_HALTED;
                        opcode_d = WAIT_OP;
                    end else begin
                        state_d   = S_EXEC;
                        opcode_d  = fetch_word[23:16];
                        rdest_d   = fetch_word[15:12];
                        rsrc_d    = fetch_word[11:8];
                        imm_sel_d = fetch_word[24];
                        imm_d     = {{8{fetch_word[7]}}, fetch_word[7:0]};
                    end
                end
                S_EXEC: begin
                    state_d = S_WRITE;
                    wen_d   = (opcode_q != WAIT_OP);
                end
                S_WRITE: begin
                    // ALU has settled for a full cycle; retire on this edge.
                    if (opcode_q != WAIT_OP) begin
                        flags_d = alu_flags;
                        count_d = count_q + 16'd1;
                    end
                    pc_d     = pc_q + 1'b1;
                    opcode_d = WAIT_OP;
                    state_d  = run ? S_FETCH : S_IDLE;
                end
                S_HALTED: begin
                    state_d = S_HALTED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            opcode_q  <= 8'h00;
            rdest_q   <= 4'd0;
            rsrc_q    <= 4'd0;
            imm_sel_q <= 1'b0;
            imm_q     <= 16'd0;
            wen_q     <= 1'b0;
            flags_q   <= 5'd0;
            count_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            rdest_q   <= rdest_d;
            rsrc_q    <= rsrc_d;
            imm_sel_q <= imm_sel_d;
            imm_q     <= imm_d;
            wen_q     <= wen_d;
            flags_q   <= flags_d;
            count_q   <= count_d;
        end
    end

    // A clear arriving during WRITE must suppress the strobe in that very
    // cycle, so the registered strobe is gated by the live clear input.
    assign wEnable     = wen_q & ~clear_pulse;
    assign opcode      = opcode_q;
    assign rdest_sel   = rdest_q;
    assign rsrc_sel    = rsrc_q;
    assign imm_sel     = imm_sel_q;
    assign imm         = imm_q;
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WRITE);
    assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Testbench for alu_program_sequencer: table-driven single steps, a run/wrap
// sequence, randomized programs against an instruction-level model, and
// hand-written HALT / collision / reset sequences.
module tb_alu_program_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        step_pulse;
    logic        run;
    logic        clear_pulse;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [24:0] prog_data;
    logic [4:0]  alu_flags;
    logic [7:0]  opcode;
    logic [3:0]  rdest_sel;
    logic [3:0]  rsrc_sel;
    logic        imm_sel;
    logic [15:0] imm;
    logic        wEnable;
    logic [3:0]  pc;
    logic [4:0]  flags_q;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    alu_program_sequencer dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .step_pulse  (step_pulse),
        .run         (run),
        .clear_pulse (clear_pulse),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .alu_flags   (alu_flags),
        .opcode      (opcode),
        .rdest_sel   (rdest_sel),
        .rsrc_sel    (rsrc_sel),
        .imm_sel     (imm_sel),
        .imm         (imm),
        .wEnable     (wEnable),
        .pc          (pc),
        .flags_q     (flags_q),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int          n_checks = 0;
    int          n_fail   = 0;
    // Instruction-level model state
    logic [24:0] m_mem [16];
    logic [3:0]  m_pc;
    logic [15:0] m_count;
    logic [4:0]  m_flags;

    typedef struct {
        logic [24:0] instr;
        logic [4:0]  flags;
        logic [7:0]  e_op;
        logic [3:0]  e_rd;
        logic [3:0]  e_rs;
        logic        e_isel;
        logic [15:0] e_imm;
        logic        e_wen;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic prog(input logic [3:0] a, input logic [24:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
        m_mem[a]  = d;
    endtask

    task automatic do_clear();
        clear_pulse = 1'b1;
        tick();
        clear_pulse = 1'b0;
        m_pc = 4'd0;
    endtask

    task automatic check_ctx(input string tag);
        chk({tag, "_pc"},    {28'd0, pc},          {28'd0, m_pc});
        chk({tag, "_count"}, {16'd0, instr_count}, {16'd0, m_count});
        chk({tag, "_flags"}, {27'd0, flags_q},     {27'd0, m_flags});
    endtask

    initial begin
        logic [24:0] w;
        logic [4:0]  f;
        int          strobes;
        int          last;
        int          cycles;
        logic        done;
        logic        inject;

        tbl[0] = '{{1'b1, 8'h05, 4'd1, 4'd0, 8'hFE}, 5'h0A, 8'h05, 4'd1, 4'd0, 1'b1, 16'hFFFE, 1'b1};
        tbl[1] = '{{1'b0, 8'h00, 4'd3, 4'd2, 8'h7F}, 5'h1F, 8'h00, 4'd3, 4'd2, 1'b0, 16'h007F, 1'b0};
        tbl[2] = '{{1'b0, 8'h12, 4'hF, 4'hE, 8'h80}, 5'h03, 8'h12, 4'hF, 4'hE, 1'b0, 16'hFF80, 1'b1};
        tbl[3] = '{{1'b1, 8'hA5, 4'h0, 4'hF, 8'h01}, 5'h11, 8'hA5, 4'h0, 4'hF, 1'b1, 16'h0001, 1'b1};
        tbl[4] = '{{1'b0, 8'hFE, 4'h7, 4'h7, 8'hFF}, 5'h1C, 8'hFE, 4'h7, 4'h7, 1'b0, 16'hFFFF, 1'b1};

        reset_n = 1'b0; step_pulse = 1'b0; run = 1'b0; clear_pulse = 1'b0;
        prog_we = 1'b0; prog_addr = 4'd0; prog_data = 25'd0; alu_flags = 5'd0;
        m_pc = 4'd0; m_count = 16'd0; m_flags = 5'd0;
        tick();
        chk("rst_opcode", {24'd0, opcode}, 32'h0);
        chk("rst_wen",    {31'd0, wEnable}, 32'h0);
        chk("rst_busy",   {31'd0, busy}, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'h0);
        chk("rst_imm",    {16'd0, imm}, 32'h0);
        chk("rst_rdest",  {28'd0, rdest_sel}, 32'h0);
        check_ctx("rst");
        reset_n = 1'b1;
        tick();

        // Table-driven single steps, one instruction per store address.
        for (int i = 0; i < 5; i++) begin
            prog(i[3:0], tbl[i].instr);
            alu_flags  = tbl[i].flags;
            step_pulse = 1'b1;
            tick();
            step_pulse = 1'b0;
            chk("fetch_busy",   {31'd0, busy}, 32'h1);
            chk("fetch_opcode", {24'd0, opcode}, 32'h0);
            tick();
            chk("exec_opcode",  {24'd0, opcode}, {24'd0, tbl[i].e_op});
            chk("exec_rdest",   {28'd0, rdest_sel}, {28'd0, tbl[i].e_rd});
            chk("exec_rsrc",    {28'd0, rsrc_sel}, {28'd0, tbl[i].e_rs});
            chk("exec_immsel",  {31'd0, imm_sel}, {31'd0, tbl[i].e_isel});
            chk("exec_imm",     {16'd0, imm}, {16'd0, tbl[i].e_imm});
            chk("exec_wen",     {31'd0, wEnable}, 32'h0);
            tick();
            chk("write_wen",    {31'd0, wEnable}, {31'd0, tbl[i].e_wen});
            chk("write_opcode", {24'd0, opcode}, {24'd0, tbl[i].e_op});
            tick();
            chk("idle_wen",     {31'd0, wEnable}, 32'h0);
            chk("idle_busy",    {31'd0, busy}, 32'h0);
            if (tbl[i].e_wen) begin
                m_count = m_count + 16'd1;
                m_flags = tbl[i].flags;
            end
            m_pc = m_pc + 4'd1;
            check_ctx("step");
        end

        // Run mode over 16 ADDs: strobes 3 cycles apart, pc wraps to 0.
        do_clear();
        for (int i = 0; i < 16; i++) begin
            prog(i[3:0], {1'b0, 8'h01, i[3:0], 4'(15 - i), 8'(i * 3)});
        end
        run = 1'b1;
        strobes = 0; last = -1; cycles = 0;
        while (strobes < 16 && cycles < 100) begin
            tick();
            cycles++;
            alu_flags = 5'($urandom_range(0, 31));
            if (wEnable) begin
                strobes++;
                if (last >= 0) chk("run_spacing", cycles - last, 3);
                last = cycles;
                chk("run_pc", {28'd0, pc}, strobes - 1);
                m_count = m_count + 16'd1;
                m_flags = alu_flags;
                if (strobes == 16) run = 1'b0;
            end
        end
        chk("run_strobes", strobes, 16);
        chk("run_cycles", cycles, 48);
        tick();
        chk("run_busy", {31'd0, busy}, 32'h0);
        m_pc = 4'd0;
        check_ctx("run");

        // Randomized program against the instruction-level model.
        for (int i = 0; i < 16; i++) begin
            w = 25'($urandom);
            case ($urandom_range(0, 9))
                0:       w[23:16] = 8'h00;
                1:       w[23:16] = 8'hFF;
                default: w[23:16] = 8'($urandom_range(1, 254));
            endcase
            prog(i[3:0], w);
        end
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                w = 25'($urandom);
                if (w[23:16] == 8'hFF) w[23:16] = 8'h3C;
                prog(4'($urandom_range(0, 15)), w);
            end
            w = m_mem[m_pc];
            f = 5'($urandom_range(0, 31));
            alu_flags  = f;
            inject     = ($urandom_range(0, 2) == 0);
            step_pulse = 1'b1;
            tick();
            step_pulse = inject;
            strobes = 0; done = 1'b0;
            for (int c = 0; c < 8 && !done; c++) begin
                tick();
                step_pulse = 1'b0;
                if (wEnable) begin
                    strobes++;
                    chk("rnd_opcode", {24'd0, opcode}, {24'd0, w[23:16]});
                    chk("rnd_rdest",  {28'd0, rdest_sel}, {28'd0, w[15:12]});
                    chk("rnd_rsrc",   {28'd0, rsrc_sel}, {28'd0, w[11:8]});
                    chk("rnd_immsel", {31'd0, imm_sel}, {31'd0, w[24]});
                    chk("rnd_imm",    {16'd0, imm}, 32'(signed'(w[7:0])) & 32'hFFFF);
                end
                if (!busy) done = 1'b1;
            end
            chk("rnd_done", {31'd0, done}, 32'h1);
            if (w[23:16] == 8'hFF) begin
                chk("rnd_halted", {31'd0, halted}, 32'h1);
                chk("rnd_strobes", strobes, 0);
                check_ctx("rnd_halt");
                do_clear();
                chk("rnd_unhalt", {31'd0, halted}, 32'h0);
            end else begin
                chk("rnd_strobes", strobes, (w[23:16] != 8'h00) ? 1 : 0);
                if (w[23:16] != 8'h00) begin
                    m_count = m_count + 16'd1;
                    m_flags = f;
                end
                m_pc = m_pc + 4'd1;
                check_ctx("rnd");
            end
        end

        // HALT under run: two ADDs retire, then halt at pc 2.
        do_clear();
        prog(4'd0, {1'b0, 8'h01, 4'd1, 4'd2, 8'h05});
        prog(4'd1, {1'b0, 8'h01, 4'd2, 4'd1, 8'h06});
        prog(4'd2, {1'b0, 8'hFF, 4'd0, 4'd0, 8'h00});
        alu_flags = 5'h15;
        run = 1'b1;
        strobes = 0; cycles = 0;
        while (!halted && cycles < 20) begin
            tick();
            cycles++;
            if (wEnable) begin
                strobes++;
                m_count = m_count + 16'd1;
                m_flags = alu_flags;
            end
        end
        chk("halt_reached", {31'd0, halted}, 32'h1);
        chk("halt_strobes", strobes, 2);
        chk("halt_opcode",  {24'd0, opcode}, 32'h0);
        m_pc = 4'd2;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (wEnable) strobes++;
        end
        run = 1'b0;
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        tick();
        tick();
        chk("halt_no_wen", strobes, 2);
        chk("halt_held",   {31'd0, halted}, 32'h1);
        chk("halt_busy",   {31'd0, busy}, 32'h0);
        check_ctx("halt");
        do_clear();
        chk("halt_clr_halted", {31'd0, halted}, 32'h0);
        chk("halt_clr_pc",     {28'd0, pc}, 32'h0);

        // prog_we during EXEC must not modify the store.
        prog(4'd0, {1'b0, 8'h11, 4'd2, 4'd3, 8'h04});
        alu_flags = 5'h0E;
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        tick();
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = {1'b0, 8'h22, 4'd5, 4'd5, 8'h55};
        tick();
        prog_we = 1'b0;
        tick();
        m_count = m_count + 16'd1; m_flags = 5'h0E; m_pc = 4'd1;
        check_ctx("guard_step");
        do_clear();
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        tick();
        chk("guard_opcode", {24'd0, opcode}, 32'h11);
        tick();
        tick();
        m_count = m_count + 16'd1; m_pc = 4'd1;
        check_ctx("guard_rerun");

        // clear_pulse during WRITE: no strobe, no retire, pc 0.
        alu_flags = ~m_flags;
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        tick();
        tick();
        chk("cw_strobe", {31'd0, wEnable}, 32'h1);
        clear_pulse = 1'b1;
        #1;
        chk("cw_wen", {31'd0, wEnable}, 32'h0);
        tick();
        clear_pulse = 1'b0;
        m_pc = 4'd0;
        chk("cw_busy", {31'd0, busy}, 32'h0);
        check_ctx("cw");
        tick();
        chk("cw_idle_wen", {31'd0, wEnable}, 32'h0);

        // Asynchronous reset in the middle of WRITE.
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        tick();
        tick();
        chk("ar_strobe", {31'd0, wEnable}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("ar_wen",    {31'd0, wEnable}, 32'h0);
        chk("ar_busy",   {31'd0, busy}, 32'h0);
        chk("ar_halted", {31'd0, halted}, 32'h0);
        chk("ar_pc",     {28'd0, pc}, 32'h0);
        chk("ar_count",  {16'd0, instr_count}, 32'h0);
        tick();
        reset_n = 1'b1;
        m_pc = 4'd0; m_count = 16'd0; m_flags = 5'd0;
        tick();
        check_ctx("ar");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
